// File: rtl/cevero_dvfs_sequencer.sv
// DVFS sequencer: applies a requested voltage/frequency point in a safe order.
// Voltage rises settle before frequency rises; frequency drops precede voltage drops.
module cevero_dvfs_sequencer #(
    parameter logic [2:0]  DefVoltage       = 3'd5,
    parameter logic [31:0] DefFreq          = 32'd100,
    parameter int unsigned VoltSettleCycles = 16,
    parameter int unsigned LockTimeout      = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [2:0]  target_voltage_i,
    input  logic [31:0] target_freq_i,
    output logic        vreg_req_o,
    output logic [2:0]  vreg_voltage_o,
    input  logic        vreg_ack_i,
    output logic        clk_req_o,
    output logic [31:0] clk_freq_o,
    input  logic        clk_lock_i,
    output logic [2:0]  cur_voltage_o,
    output logic [31:0] cur_freq_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int SW = $clog2(VoltSettleCycles + 1);
    localparam int LW = $clog2(LockTimeout + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VREQ,
        S_VSETTLE,
        S_FREQ,
        S_VREQ_LAST,
        S_DONE
    } state_e;

    state_e        r_state, w_state_nxt;
    logic [2:0]    r_tgt_v, w_tgt_v_nxt;
    logic [31:0]   r_tgt_f, w_tgt_f_nxt;
    logic [2:0]    r_cur_v, w_cur_v_nxt;
    logic [31:0]   r_cur_f, w_cur_f_nxt;
    logic          r_err, w_err_nxt;
    logic [SW-1:0] r_scnt, w_scnt_nxt;
    logic [LW-1:0] r_lcnt, w_lcnt_nxt;
    logic          w_vreq;
    logic          w_creq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_tgt_v <= DefVoltage;
            r_tgt_f <= DefFreq;
            r_cur_v <= DefVoltage;
            r_cur_f <= DefFreq;
            r_err   <= 1'b0;
            r_scnt  <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt_v <= w_tgt_v_nxt;
            r_tgt_f <= w_tgt_f_nxt;
            r_cur_v <= w_cur_v_nxt;
            r_cur_f <= w_cur_f_nxt;
            r_err   <= w_err_nxt;
            r_scnt  <= w_scnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tgt_v_nxt = r_tgt_v;
        w_tgt_f_nxt = r_tgt_f;
        w_cur_v_nxt = r_cur_v;
        w_cur_f_nxt = r_cur_f;
        w_err_nxt   = r_err;
        w_scnt_nxt  = '0;
        w_lcnt_nxt  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (target_voltage_i != r_cur_v || target_freq_i != r_cur_f) begin
                    w_tgt_v_nxt = target_voltage_i;
                    w_tgt_f_nxt = target_freq_i;
                    if (target_voltage_i > r_cur_v) begin
                        w_state_nxt = S_VREQ;
                    end else if (target_freq_i != r_cur_f) begin
                        w_state_nxt = S_FREQ;
                    end else begin
                        w_state_nxt = S_VREQ_LAST;
                    end
                end
            end
            S_VREQ, S_VREQ_LAST: begin
                if (vreg_ack_i) begin
                    w_cur_v_nxt = r_tgt_v;
                    w_state_nxt = (r_state == S_VREQ) ? S_VSETTLE : S_DONE;
                end
            end
            S_VSETTLE: begin
                w_scnt_nxt = r_scnt + 1'b1;
                if (r_scnt == SW'(VoltSettleCycles - 1)) begin
                    w_scnt_nxt  = '0;
                    w_state_nxt = (r_tgt_f != r_cur_f) ? S_FREQ : S_DONE;
                end
            end
            S_FREQ: begin
                w_lcnt_nxt = r_lcnt + 1'b1;
                if (clk_lock_i) begin
                    w_lcnt_nxt  = '0;
                    w_cur_f_nxt = r_tgt_f;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = (r_tgt_v < r_cur_v) ? S_VREQ_LAST : S_DONE;
                end else if (r_lcnt == LW'(LockTimeout - 1)) begin
                    // Abandon the change; a raised voltage is kept, a pending drop is skipped
                    w_lcnt_nxt  = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_vreq = (r_state == S_VREQ) || (r_state == S_VREQ_LAST);
    assign w_creq = (r_state == S_FREQ);

    assign vreg_req_o     = w_vreq;
    assign clk_req_o      = w_creq;
    assign vreg_voltage_o = w_vreq ? r_tgt_v : r_cur_v;
    assign clk_freq_o     = w_creq ? r_tgt_f : r_cur_f;
    assign cur_voltage_o  = r_cur_v;
    assign cur_freq_o     = r_cur_f;
    assign busy_o         = w_vreq || w_creq || (r_state == S_VSETTLE);
    assign done_o         = (r_state == S_DONE);
    assign error_o        = r_err;

endmodule

// File: tb/tb_cevero_dvfs_sequencer.sv
// Bench for cevero_dvfs_sequencer: directed and random operating-point changes
// with an auto-responding regulator/clock generator and a point-level model.
module tb_cevero_dvfs_sequencer;

    logic        clk_i;
    logic        rst_ni;
    logic [2:0]  target_voltage_i;
    logic [31:0] target_freq_i;
    logic        vreg_req_o;
    logic [2:0]  vreg_voltage_o;
    logic        vreg_ack_i;
    logic        clk_req_o;
    logic [31:0] clk_freq_o;
    logic        clk_lock_i;
    logic [2:0]  cur_voltage_o;
    logic [31:0] cur_freq_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    cevero_dvfs_sequencer dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .target_voltage_i (target_voltage_i),
        .target_freq_i    (target_freq_i),
        .vreg_req_o       (vreg_req_o),
        .vreg_voltage_o   (vreg_voltage_o),
        .vreg_ack_i       (vreg_ack_i),
        .clk_req_o        (clk_req_o),
        .clk_freq_o       (clk_freq_o),
        .clk_lock_i       (clk_lock_i),
        .cur_voltage_o    (cur_voltage_o),
        .cur_freq_o       (cur_freq_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // responder settings
    int ack_dly = 1;
    int lock_dly = 1;
    bit stray = 0;
    int vc = 0;
    int cc = 0;

    // monitor records, cleared per transaction
    int m_vn, m_cn, m_v_first, m_c_first, m_ack_cyc;
    int m_c_run, m_c_len, m_dn, m_d_cyc, m_ovl, m_busy_rise, m_unst;
    logic [2:0]  m_vv;
    logic [31:0] m_cf;
    bit p_v = 0;
    bit p_c = 0;
    bit p_b = 0;

    // model of the applied point
    logic [2:0]  mv = 3'd5;
    logic [31:0] mf = 32'd100;
    logic        merr = 1'b0;

    initial begin
        clk_i = 0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic clr_mon();
        m_vn = 0; m_cn = 0; m_v_first = -1; m_c_first = -1; m_ack_cyc = -1;
        m_c_run = 0; m_c_len = 0; m_dn = 0; m_d_cyc = -1; m_ovl = 0;
        m_busy_rise = -1; m_unst = 0; m_vv = 'x; m_cf = 'x;
    endtask

    initial begin
        vreg_ack_i = 0;
        clk_lock_i = 0;
        clr_mon();
        forever begin
            @(negedge clk_i);
            if (vreg_req_o && !p_v) begin
                m_vn++;
                m_v_first = (m_vn == 1) ? cyc : m_v_first;
                m_vv = vreg_voltage_o;
            end
            if (vreg_req_o && vreg_voltage_o !== m_vv) m_unst++;
            if (clk_req_o) begin
                if (!p_c) begin
                    m_cn++;
                    m_c_first = (m_cn == 1) ? cyc : m_c_first;
                    m_c_run = 0;
                    m_cf = clk_freq_o;
                end
                if (clk_freq_o !== m_cf) m_unst++;
                m_c_run++;
            end else if (p_c) begin
                m_c_len = m_c_run;
            end
            if (vreg_req_o && clk_req_o) m_ovl++;
            if (done_o) begin
                m_dn++;
                m_d_cyc = cyc;
            end
            if (busy_o && !p_b) m_busy_rise = cyc;
            p_v = vreg_req_o;
            p_c = clk_req_o;
            p_b = busy_o;
            vreg_ack_i = 0;
            clk_lock_i = 0;
            if (vreg_req_o) begin
                vc++;
                if (vc == ack_dly) begin
                    vreg_ack_i = 1;
                    m_ack_cyc = cyc + 1;
                end
            end else begin
                vc = 0;
                if (stray && $urandom_range(0, 5) == 0) vreg_ack_i = 1;
            end
            if (clk_req_o) begin
                cc++;
                if (cc == lock_dly) clk_lock_i = 1;
            end else begin
                cc = 0;
                if (stray && $urandom_range(0, 5) == 0) clk_lock_i = 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (m_dn == 0 && n < bound) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("done_seen", 32'(m_dn != 0), 32'd1);
    endtask

    task automatic chk_point(input string tag);
        chk({tag, "_cur_v"}, 32'(cur_voltage_o), 32'(mv));
        chk({tag, "_cur_f"}, cur_freq_o, mf);
        chk({tag, "_vreg_v"}, 32'(vreg_voltage_o), 32'(mv));
        chk({tag, "_clk_f"}, clk_freq_o, mf);
        chk({tag, "_err"}, 32'(error_o), 32'(merr));
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    // One request; expectations follow from the ordering rules on operating points
    task automatic txn(input logic [2:0] tv, input logic [31:0] tf,
                       input int ad, input int ld);
        bit same, raise, fch, lok;
        int env, enc;
        same = (tv == mv) && (tf == mf);
        raise = tv > mv;
        fch = tf != mf;
        lok = (ld >= 1) && (ld <= 64);
        enc = fch ? 1 : 0;
        env = (raise || !fch || (lok && tv < mv)) ? 1 : 0;
        ack_dly = ad;
        lock_dly = ld;
        clr_mon();
        target_voltage_i = tv;
        target_freq_i = tf;
        if (same) begin
            repeat (20) @(posedge clk_i);
            #1;
            chk("same_done", 32'(m_dn), 32'd0);
            chk("same_vreq", 32'(m_vn + m_cn), 32'd0);
            chk_point("same");
            return;
        end
        if (raise || !fch || lok) mv = tv;
        if (fch && lok) mf = tf;
        if (fch) merr = !lok;
        wait_done(400);
        target_voltage_i = mv;
        target_freq_i = mf;
        chk_point("txn");
        chk("n_done", 32'(m_dn), 32'd1);
        chk("n_vreq", 32'(m_vn), 32'(env));
        chk("n_creq", 32'(m_cn), 32'(enc));
        chk("overlap", 32'(m_ovl), 32'd0);
        chk("stable", 32'(m_unst), 32'd0);
        if (env == 1) chk("vreg_data", 32'(m_vv), 32'(tv));
        if (enc == 1) begin
            chk("clk_data", m_cf, tf);
            chk("creq_len", 32'(m_c_len), lok ? 32'(ld) : 32'd64);
        end
        if (env == 1 && enc == 1) begin
            if (raise) begin
                chk("order_up", 32'(m_v_first < m_c_first), 32'd1);
                chk("settle", 32'(m_c_first - m_ack_cyc), 32'd16);
            end else begin
                chk("order_dn", 32'(m_c_first < m_v_first), 32'd1);
            end
        end
    endtask

    initial begin
        int d1;
        logic [2:0] rv;
        logic [31:0] rf;
        int rl;
        rst_ni = 0;
        target_voltage_i = 3'd5;
        target_freq_i = 32'd100;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req", 32'({vreg_req_o, clk_req_o, busy_o, done_o}), 32'd0);
        chk_point("rst");
        @(negedge clk_i);
        rst_ni = 1;

        txn(3'd5, 32'd100, 1, 1);
        txn(3'd6, 32'd150, 3, 5);
        txn(3'd3, 32'd50, 2, 4);
        txn(3'd3, 32'd40, 1, 0);

        // retarget during the settle window
        ack_dly = 2;
        lock_dly = 3;
        clr_mon();
        target_voltage_i = 3'd6;
        target_freq_i = 32'd120;
        for (int i = 0; i < 50 && m_ack_cyc < 0; i++) begin
            @(posedge clk_i);
            #1;
        end
        repeat (4) @(posedge clk_i);
        #1;
        target_voltage_i = 3'd7;
        target_freq_i = 32'd200;
        wait_done(200);
        mv = 3'd6;
        mf = 32'd120;
        merr = 1'b0;
        chk("retgt_v", 32'(cur_voltage_o), 32'(mv));
        chk("retgt_f", cur_freq_o, mf);
        chk("retgt_err", 32'(error_o), 32'd0);
        d1 = m_d_cyc;
        clr_mon();
        wait_done(200);
        mv = 3'd7;
        mf = 32'd200;
        chk("reeval_gap", 32'(m_busy_rise - d1), 32'd2);
        chk_point("retgt2");

        txn(3'd7, 32'd90, 2, 64);
        txn(3'd7, 32'd80, 2, 65);
        txn(3'd4, 32'd80, 3, 1);

        stray = 1;
        for (int i = 0; i < 24; i++) begin
            rv = 3'($urandom_range(0, 7));
            rf = ($urandom_range(0, 3) == 0) ? mf : 32'($urandom_range(1, 400));
            case ($urandom_range(0, 9))
                0: rl = 0;
                1: rl = 64;
                2: rl = 65;
                default: rl = $urandom_range(1, 8);
            endcase
            txn(rv, rf, $urandom_range(1, 6), rl);
        end
        stray = 0;

        // reset while the regulator request is pending
        ack_dly = 1000;
        target_voltage_i = (mv == 3'd5) ? 3'd6 : 3'd5;
        target_freq_i = mf;
        for (int i = 0; i < 10 && !vreg_req_o; i++) begin
            @(posedge clk_i);
            #1;
        end
        chk("pre_rst_vreq", 32'(vreg_req_o), 32'd1);
        #2;
        rst_ni = 0;
        #1;
        chk("async_vreq", 32'(vreg_req_o), 32'd0);
        mv = 3'd5;
        mf = 32'd100;
        merr = 1'b0;
        chk_point("async");
        target_voltage_i = 3'd5;
        target_freq_i = 32'd100;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        clr_mon();
        repeat (6) @(posedge clk_i);
        #1;
        chk("post_rst_act", 32'(m_vn + m_cn + m_dn), 32'd0);
        chk_point("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
